parser_action_engine: RTL and testbench
=======================================

PARSER_ACTION_ENGINE -- requirements
Module: parser_action_engine

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, segment width in bits.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, tuser width.
REQ-003 SHALL have parameter C_NUM_SEGS, default 4, header segments per packet.
REQ-004 SHALL have parameter C_NUM_ACTIONS, default 10, parallel parse actions (1..16).
REQ-005 SHALL have parameter C_NUM_CONT, default 8, containers per type (2B/4B/6B).
REQ-006 SHALL have parameter C_TBL_DEPTH, default 32, action-table entries (power of 2).
REQ-007 SHALL have parameter C_VLANID_WIDTH, default 12; PHV_LEN = C_NUM_CONT*96+256.
REQ-008 SHALL have ports: axis_clk in 1 clock; areset in 1 async active-high reset.
REQ-009 SHALL have ports: tdata_segs in C_NUM_SEGS*C_AXIS_DATA_WIDTH header; tuser_1st in C_AXIS_TUSER_WIDTH; vlan_id in C_VLANID_WIDTH.
REQ-010 SHALL have ports: segs_fifo_empty, vlan_fifo_empty in 1; segs_fifo_rd, vlan_fifo_rd out 1 pop strobes.
REQ-011 SHALL have ports: phv_valid out 1; phv_ready in 1; phv out PHV_LEN; phv_err out 1.
REQ-012 SHALL have ports: tbl_wr_en in 1; tbl_wr_addr in log2(C_TBL_DEPTH); tbl_wr_data in 16*C_NUM_ACTIONS.

Function
REQ-013 Action (16b): [0] valid; [3:1] container index; [5:4] type 01=2B,10=4B,11=6B,00=none; [15:6] byte offset; action k at tbl_wr_data[16k+:16].
REQ-014 Table index = vlan_id[4 +: log2(C_TBL_DEPTH)]; read latency 1 cycle; same-cycle write/read same address returns old data.
REQ-015 States: IDLE -> RD_TBL when !vlan_fifo_empty; RD_TBL -> EXTRACT; EXTRACT -> ASSEMBLE when !segs_fifo_empty; ASSEMBLE -> IDLE when output slot free, else hold.
REQ-016 Extraction: byte at offset is container MSB (network order); header byte 0 = tdata_segs[7:0].
REQ-017 Action with valid=0, type=00, or offset+size > C_NUM_SEGS*C_AXIS_DATA_WIDTH/8 SHALL write nothing; out-of-range also sets packet error.
REQ-018 Two actions targeting same container: higher action index wins.
REQ-019 Containers not written for a packet SHALL be zero.
REQ-020 phv = {6B[N-1..0], 4B[N-1..0], 2B[N-1..0], zero pad, vlan_id, err, tuser_1st}, metadata field 256 bits.
REQ-021 Output slot free = !phv_valid or phv_ready; on ASSEMBLE transfer: load phv/phv_err, set phv_valid, pulse segs_fifo_rd and vlan_fifo_rd one cycle.
REQ-022 phv_valid SHALL stay high and phv stable until phv_ready; next packet MAY proceed through EXTRACT meanwhile (one packet overlap).
REQ-023 Latency: vlan_fifo non-empty in IDLE, segs non-empty, output free -> phv_valid 4 cycles later; throughput one PHV per 4 cycles.
REQ-024 Back-to-back phv_valid/phv_ready with new transfer same cycle SHALL keep phv_valid high with new data.

Reset
REQ-025 areset SHALL asynchronously force IDLE, phv_valid=0, phv=0, phv_err=0, fifo rd strobes 0, containers 0; table contents undefined.
REQ-026 Reset mid-packet SHALL drop it without popping FIFOs.

Configuration
REQ-027 PARSER_ERR_CNT_EN defined: 32-bit saturating port err_cnt out counts PHVs transferred with phv_err=1, reset 0.
REQ-028 PARSER_ERR_CNT_EN undefined: err_cnt port and counter absent; phv_err unaffected.

Structure
REQ-029 Shared package parser_pkg SHALL hold action field offsets, type codes, state encodings, metadata width 256.
REQ-030 One sub-module parser_field_extract (one action -> value, type, index, err), instantiated C_NUM_ACTIONS times.

Verification
REQ-031 Table[0] action0 = {offset 12, 2B, cont 0, valid}; header bytes 12..13 = 08 00 -> 2B[0]=16'h0800, others 0, phv_err=0.
REQ-032 Actions 0 and 5 both to 4B cont 3 from offsets 26 and 30 -> 4B[3] = bytes 30..33.
REQ-033 6B action offset 124 with 4 segs -> container 0, phv_err=1; err_cnt increments by 1 when PARSER_ERR_CNT_EN.
REQ-034 phv_ready low 20 cycles, two packets queued -> first PHV stable 20 cycles, second emitted immediately after, FIFO pops exactly 2.
REQ-035 vlan_id=12'h010 and 12'h020 with differing table entries 1/2 -> each PHV uses its own entry.
REQ-036 areset asserted in EXTRACT -> no pops, phv_valid=0; next packet parses correctly.

Source files
------------

// File: rtl/parser_pkg.sv
// Shared definitions for the parser action engine: action word field layout,
// container type codes, FSM state encoding and the PHV metadata width.
package parser_pkg;

    localparam int ACT_W         = 16;
    localparam int ACT_VALID_BIT = 0;
    localparam int ACT_IDX_LSB   = 1;
    localparam int ACT_IDX_W     = 3;
    localparam int ACT_TYPE_LSB  = 4;
    localparam int ACT_TYPE_W    = 2;
    localparam int ACT_OFF_LSB   = 6;
    localparam int ACT_OFF_W     = 10;

    // Width of the metadata field at the bottom of every PHV.
    localparam int META_W        = 256;

    typedef enum logic [1:0] {
        TYPE_NONE = 2'b00,
        TYPE_2B   = 2'b01,
        TYPE_4B   = 2'b10,
        TYPE_6B   = 2'b11
    } cont_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_TBL   = 2'd1,
        ST_EXTRACT  = 2'd2,
        ST_ASSEMBLE = 2'd3
    } state_e;

    // Number of header bytes a container of the given type holds.
    function automatic logic [3:0] type_bytes(input logic [1:0] t);
        case (t)
            TYPE_2B: return 4'd2;
            TYPE_4B: return 4'd4;
            TYPE_6B: return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/parser_field_extract.sv
// One parse action: decodes a 16-bit action word and pulls the addressed
// bytes out of the packet header in network order (first byte = MSB).
// The value is right-aligned in 48 bits; wr says it should be written,
// err flags an enabled action that runs past the end of the header.
module parser_field_extract
    import parser_pkg::*;
#(
    parameter int HDR_W = 1024
) (
    input  logic [HDR_W-1:0]     hdr,
    input  logic [ACT_W-1:0]     action,
    output logic [47:0]          value,
    output logic [1:0]           ctype,
    output logic [ACT_IDX_W-1:0] cidx,
    output logic                 wr,
    output logic                 err
);

    localparam int HDR_BYTES = HDR_W / 8;

    logic [ACT_OFF_W-1:0] off;
    logic [3:0]           size;
    logic [HDR_W-1:0]     shifted;
    logic [47:0]          be;
    logic                 live;
    logic                 in_range;

    // Decode the action, bounds-check it and assemble the big-endian value.
    always_comb begin
        off      = action[ACT_OFF_LSB +: ACT_OFF_W];
        ctype    = action[ACT_TYPE_LSB +: ACT_TYPE_W];
        cidx     = action[ACT_IDX_LSB +: ACT_IDX_W];
        size     = type_bytes(ctype);
        live     = action[ACT_VALID_BIT] && (ctype != TYPE_NONE);
        in_range = (32'(off) + 32'(size)) <= 32'(HDR_BYTES);
        // Header byte 0 sits in the low bits, so shift the wanted byte down.
        shifted  = hdr >> {off, 3'b000};
        for (int b = 0; b < 6; b++) begin
            be[(5 - b) * 8 +: 8] = shifted[b * 8 +: 8];
        end
        // Keep only the first 'size' bytes, right-aligned.
        value    = be >> {(4'd6 - size), 3'b000};
        wr       = live && in_range;
        err      = live && !in_range;
    end

endmodule

// File: rtl/parser_action_engine.sv
// Parser action engine: looks up a per-VLAN action table, runs all parse
// actions in parallel over the packet header and emits one PHV per packet
// on a valid/ready output.
// Output handshake: phv/phv_err are held stable while phv_valid is high and
// a transfer completes on any cycle where phv_valid && phv_ready.
// Optional feature: define PARSER_ERR_CNT_EN to add the saturating err_cnt port.
module parser_action_engine
    import parser_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 4,
    parameter int C_NUM_ACTIONS      = 10,
    parameter int C_NUM_CONT         = 8,
    parameter int C_TBL_DEPTH        = 32,
    parameter int C_VLANID_WIDTH     = 12,
    localparam int PHV_LEN           = C_NUM_CONT * 96 + 256,
    localparam int TBL_AW            = $clog2(C_TBL_DEPTH)
) (
    input  logic                                    axis_clk,
    input  logic                                    areset,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_1st,
    input  logic [C_VLANID_WIDTH-1:0]               vlan_id,
    input  logic                                    segs_fifo_empty,
    input  logic                                    vlan_fifo_empty,
    output logic                                    segs_fifo_rd,
    output logic                                    vlan_fifo_rd,
    output logic                                    phv_valid,
    input  logic                                    phv_ready,
    output logic [PHV_LEN-1:0]                      phv,
    output logic                                    phv_err,
    input  logic                                    tbl_wr_en,
    input  logic [TBL_AW-1:0]                       tbl_wr_addr,
    input  logic [16*C_NUM_ACTIONS-1:0]             tbl_wr_data,
`ifdef PARSER_ERR_CNT_EN
    output logic [31:0]                             err_cnt,
`endif
    output logic [1:0]                              dbg_state
);

    localparam int HDR_W = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
    localparam int TBL_W = ACT_W * C_NUM_ACTIONS;
    localparam int PAD_W = META_W - C_VLANID_WIDTH - 1 - C_AXIS_TUSER_WIDTH;

    logic [TBL_W-1:0] tbl_mem [C_TBL_DEPTH];

    state_e                         state_q, state_d;
    logic [TBL_W-1:0]               act_q, act_d;
    logic [C_NUM_CONT-1:0][15:0]    c2_q, c2_d, m2;
    logic [C_NUM_CONT-1:0][31:0]    c4_q, c4_d, m4;
    logic [C_NUM_CONT-1:0][47:0]    c6_q, c6_d, m6;
    logic                           cerr_q, cerr_d, merr;
    logic [PHV_LEN-1:0]             phv_q, phv_d;
    logic                           phv_err_q, phv_err_d;
    logic                           phv_valid_q, phv_valid_d;
    logic                           pop;
    logic                           slot_free;

    logic [C_NUM_ACTIONS-1:0][47:0]          ex_val;
    logic [C_NUM_ACTIONS-1:0][1:0]           ex_type;
    logic [C_NUM_ACTIONS-1:0][ACT_IDX_W-1:0] ex_idx;
    logic [C_NUM_ACTIONS-1:0]                ex_wr;
    logic [C_NUM_ACTIONS-1:0]                ex_err;

    // Action table storage; deliberately not reset.
    always_ff @(posedge axis_clk) begin
        if (tbl_wr_en) begin
            tbl_mem[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    for (genvar k = 0; k < C_NUM_ACTIONS; k++) begin : g_ext
        parser_field_extract #(.HDR_W(HDR_W)) u_ext (
            .hdr    (tdata_segs),
            .action (act_q[k*ACT_W +: ACT_W]),
            .value  (ex_val[k]),
            .ctype  (ex_type[k]),
            .cidx   (ex_idx[k]),
            .wr     (ex_wr[k]),
            .err    (ex_err[k])
        );
    end

    // Merge action results into fresh containers; later actions overwrite earlier.
    always_comb begin
        m2   = '0;
        m4   = '0;
        m6   = '0;
        merr = |ex_err;
        for (int k = 0; k < C_NUM_ACTIONS; k++) begin
            if (ex_wr[k] && (int'(ex_idx[k]) < C_NUM_CONT)) begin
                case (ex_type[k])
                    TYPE_2B: m2[ex_idx[k]] = ex_val[k][15:0];
                    TYPE_4B: m4[ex_idx[k]] = ex_val[k][31:0];
                    TYPE_6B: m6[ex_idx[k]] = ex_val[k];
                    default: ;
                endcase
            end
        end
    end

    // Next-state, container capture and PHV output slot control.
    always_comb begin
        slot_free   = !phv_valid_q || phv_ready;
        state_d     = state_q;
        act_d       = act_q;
        c2_d        = c2_q;
        c4_d        = c4_q;
        c6_d        = c6_q;
        cerr_d      = cerr_q;
        phv_d       = phv_q;
        phv_err_d   = phv_err_q;
        phv_valid_d = phv_valid_q && !phv_ready;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!vlan_fifo_empty) state_d = ST_RD_TBL;
            end
            ST_RD_TBL: begin
                act_d   = tbl_mem[vlan_id[4 +: TBL_AW]];
                state_d = ST_EXTRACT;
            end
            ST_EXTRACT: begin
                if (!segs_fifo_empty) begin
                    c2_d    = m2;
                    c4_d    = m4;
                    c6_d    = m6;
                    cerr_d  = merr;
                    state_d = ST_ASSEMBLE;
                end
            end
            ST_ASSEMBLE: begin
                // FIFO heads are still this packet's, so metadata comes straight from them.
                if (slot_free) begin
                    phv_d       = {c6_q, c4_q, c2_q, {PAD_W{1'b0}}, vlan_id, cerr_q, tuser_1st};
                    phv_err_d   = cerr_q;
                    phv_valid_d = 1'b1;
                    pop         = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            c2_q        <= '0;
            c4_q        <= '0;
            c6_q        <= '0;
            cerr_q      <= 1'b0;
            phv_q       <= '0;
            phv_err_q   <= 1'b0;
            phv_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            c2_q        <= c2_d;
            c4_q        <= c4_d;
            c6_q        <= c6_d;
            cerr_q      <= cerr_d;
            phv_q       <= phv_d;
            phv_err_q   <= phv_err_d;
            phv_valid_q <= phv_valid_d;
        end
    end

    assign segs_fifo_rd = pop;
    assign vlan_fifo_rd = pop;
    assign phv_valid    = phv_valid_q;
    assign phv          = phv_q;
    assign phv_err      = phv_err_q;
    assign dbg_state    = state_q;

`ifdef PARSER_ERR_CNT_EN
    logic [31:0] err_cnt_q, err_cnt_d;

    // Count errored PHVs as they leave, saturating at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (phv_valid_q && phv_ready && phv_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parser_action_engine.sv
// Bench for parser_action_engine: FIFO models feed the DUT, directed packets
// push hand-computed PHVs into a scoreboard, and a monitor checks each
// transferred PHV. Honours PARSER_ERR_CNT_EN for the err_cnt port.
module tb_parser_action_engine;
    import parser_pkg::*;

    localparam int DW      = 256;
    localparam int UW      = 128;
    localparam int NS      = 4;
    localparam int NA      = 10;
    localparam int NC      = 8;
    localparam int TD      = 32;
    localparam int VW      = 12;
    localparam int PHV_LEN = NC * 96 + 256;
    localparam int HDR_W   = NS * DW;
    localparam int TBL_W   = 16 * NA;
    localparam int EXP_W   = PHV_LEN + 1;

    // ---------------- clock / reset / DUT ----------------
    logic                 axis_clk = 1'b0;
    logic                 areset;
    logic [HDR_W-1:0]     tdata_segs;
    logic [UW-1:0]        tuser_1st;
    logic [VW-1:0]        vlan_id;
    logic                 segs_fifo_empty, vlan_fifo_empty;
    logic                 segs_fifo_rd, vlan_fifo_rd;
    logic                 phv_valid, phv_ready, phv_err;
    logic [PHV_LEN-1:0]   phv;
    logic                 tbl_wr_en;
    logic [$clog2(TD)-1:0] tbl_wr_addr;
    logic [TBL_W-1:0]     tbl_wr_data;
    logic [1:0]           dbg_state;
`ifdef PARSER_ERR_CNT_EN
    logic [31:0]          err_cnt;
`endif

    always #5 axis_clk = ~axis_clk;

    parser_action_engine dut (
        .axis_clk        (axis_clk),
        .areset          (areset),
        .tdata_segs      (tdata_segs),
        .tuser_1st       (tuser_1st),
        .vlan_id         (vlan_id),
        .segs_fifo_empty (segs_fifo_empty),
        .vlan_fifo_empty (vlan_fifo_empty),
        .segs_fifo_rd    (segs_fifo_rd),
        .vlan_fifo_rd    (vlan_fifo_rd),
        .phv_valid       (phv_valid),
        .phv_ready       (phv_ready),
        .phv             (phv),
        .phv_err         (phv_err),
        .tbl_wr_en       (tbl_wr_en),
        .tbl_wr_addr     (tbl_wr_addr),
        .tbl_wr_data     (tbl_wr_data),
`ifdef PARSER_ERR_CNT_EN
        .err_cnt         (err_cnt),
`endif
        .dbg_state       (dbg_state)
    );

    // ---------------- FIFO models and scoreboard ----------------
    logic [VW-1:0]        vq[$];
    logic [UW+HDR_W-1:0]  sq[$];
    logic [EXP_W-1:0]     exp_q[$];
    int                   vlan_pops = 0;
    int                   segs_pops = 0;
    int                   checks = 0;
    int                   errors = 0;

    function automatic void refresh();
        vlan_fifo_empty = (vq.size() == 0);
        segs_fifo_empty = (sq.size() == 0);
        vlan_id         = (vq.size() != 0) ? vq[0] : '0;
        {tuser_1st, tdata_segs} = (sq.size() != 0) ? sq[0] : '0;
    endfunction

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endfunction

    function automatic logic [15:0] act(input logic v, input logic [2:0] idx, input logic [1:0] t, input logic [9:0] off);
        return {off, t, idx, v};
    endfunction

    function automatic logic [HDR_W-1:0] make_hdr(input logic ethertype);
        logic [HDR_W-1:0] h;
        for (int i = 0; i < HDR_W / 8; i++) h[i*8 +: 8] = 8'(i);
        if (ethertype) begin
            h[12*8 +: 8] = 8'h08;
            h[13*8 +: 8] = 8'h00;
        end
        return h;
    endfunction

    function automatic logic [EXP_W-1:0] pack(input logic [NC-1:0][15:0] c2, input logic [NC-1:0][31:0] c4,
                                              input logic [NC-1:0][47:0] c6, input logic [VW-1:0] v,
                                              input logic e, input logic [UW-1:0] tu);
        return {e, c6, c4, c2, {(256 - VW - 1 - UW){1'b0}}, v, e, tu};
    endfunction

    // One clock: sample pop strobes mid-cycle, then apply them to the FIFO models.
    task automatic tick();
        logic vrd, srd;
        logic [VW-1:0] dv;
        logic [UW+HDR_W-1:0] ds;
        @(negedge axis_clk);
        vrd = vlan_fifo_rd;
        srd = segs_fifo_rd;
        @(posedge axis_clk);
        #1;
        if (vrd) begin
            vlan_pops++;
            if (vq.size() != 0) dv = vq.pop_front();
        end
        if (srd) begin
            segs_pops++;
            if (sq.size() != 0) ds = sq.pop_front();
        end
        refresh();
    endtask

    task automatic push_pkt(input logic [VW-1:0] v, input logic [HDR_W-1:0] h, input logic [UW-1:0] tu,
                            input logic [EXP_W-1:0] e);
        vq.push_back(v);
        sq.push_back({tu, h});
        exp_q.push_back(e);
        refresh();
    endtask

    task automatic tbl_write(input int addr, input logic [TBL_W-1:0] d);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = addr[$clog2(TD)-1:0];
        tbl_wr_data = d;
        tick();
        tbl_wr_en   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vq.size() != 0 || sq.size() != 0 || phv_valid) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s drain_timeout got %0d pending want 0", name, exp_q.size());
        end
    endtask

    // ---------------- monitor ----------------
    logic [EXP_W-1:0] mon_e;

    always @(negedge axis_clk) begin
        if (!areset && phv_valid && phv_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL phv_unexpected got meta %0h want no phv", phv[255:0]);
            end else begin
                mon_e = exp_q.pop_front();
                checks += 3;
                if (phv[PHV_LEN-1:256] !== mon_e[PHV_LEN-1:256]) begin
                    errors++;
                    $display("FAIL phv_cont got %0h want %0h", phv[PHV_LEN-1:256], mon_e[PHV_LEN-1:256]);
                end
                if (phv[255:0] !== mon_e[255:0]) begin
                    errors++;
                    $display("FAIL phv_meta got %0h want %0h", phv[255:0], mon_e[255:0]);
                end
                if (phv_err !== mon_e[PHV_LEN]) begin
                    errors++;
                    $display("FAIL phv_err got %0b want %0b", phv_err, mon_e[PHV_LEN]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NC-1:0][15:0] c2;
        logic [NC-1:0][31:0] c4;
        logic [NC-1:0][47:0] c6;
        logic [TBL_W-1:0]    d;
        logic [EXP_W-1:0]    e1, e2, e3, e4, ea, eb;
        logic [PHV_LEN-1:0]  held;
        logic                stable;
        int                  lat, vb, sb;

        areset      = 1'b1;
        phv_ready   = 1'b1;
        tbl_wr_en   = 1'b0;
        tbl_wr_addr = '0;
        tbl_wr_data = '0;
        refresh();
        tick();
        tick();
        check("rst_phv_valid", 64'(phv_valid), 64'd0);
        check("rst_phv_lo", phv[63:0], 64'd0);
        check("rst_phv_or", 64'(|phv), 64'd0);
        check("rst_phv_err", 64'(phv_err), 64'd0);
        check("rst_rd", 64'({segs_fifo_rd, vlan_fifo_rd}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        areset = 1'b0;
        tick();

        // Entry 0: ethertype into 2B[0].
        d = '0; d[0*16 +: 16] = act(1, 0, 2'b01, 12);
        tbl_write(0, d);
        // Entry 1: actions 0 and 5 both to 4B[3]; action 2 to 6B[1].
        d = '0; d[0*16 +: 16] = act(1, 3, 2'b10, 26); d[2*16 +: 16] = act(1, 1, 2'b11, 0);
        d[5*16 +: 16] = act(1, 3, 2'b10, 30);
        tbl_write(1, d);
        // Entry 2: 2B[2] from 40, 6B[7] from 100.
        d = '0; d[0*16 +: 16] = act(1, 2, 2'b01, 40); d[9*16 +: 16] = act(1, 7, 2'b11, 100);
        tbl_write(2, d);
        // Entry 3: out-of-range 6B, disabled, type-none and last-bytes 2B actions.
        d = '0; d[0*16 +: 16] = act(1, 0, 2'b11, 124); d[1*16 +: 16] = act(0, 4, 2'b01, 0);
        d[2*16 +: 16] = act(1, 5, 2'b00, 0); d[3*16 +: 16] = act(1, 1, 2'b01, 126);
        tbl_write(3, d);

        c2 = '0; c4 = '0; c6 = '0; c2[0] = 16'h0800;
        e1 = pack(c2, c4, c6, 12'h000, 1'b0, 128'hA1);
        c2 = '0; c4 = '0; c6 = '0; c4[3] = 32'h1E1F2021; c6[1] = 48'h000102030405;
        e2 = pack(c2, c4, c6, 12'h010, 1'b0, 128'hA2);
        c2 = '0; c4 = '0; c6 = '0; c2[2] = 16'h2829; c6[7] = 48'h646566676869;
        e3 = pack(c2, c4, c6, 12'h020, 1'b0, 128'hA3);
        c2 = '0; c4 = '0; c6 = '0; c2[1] = 16'h7E7F;
        e4 = pack(c2, c4, c6, 12'h030, 1'b1, 128'hA4);

        // Single packet with latency measurement.
        push_pkt(12'h000, make_hdr(1'b1), 128'hA1, e1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!phv_valid && lat < 20);
        check("latency", 64'(lat), 64'd4);
        drain("t1");

        // Three packets back to back, distinct table entries.
        push_pkt(12'h010, make_hdr(1'b0), 128'hA2, e2);
        push_pkt(12'h020, make_hdr(1'b0), 128'hA3, e3);
        push_pkt(12'h030, make_hdr(1'b0), 128'hA4, e4);
        drain("t234");
        check("pops_after_t4", 64'(vlan_pops), 64'd4);
`ifdef PARSER_ERR_CNT_EN
        check("err_cnt_one", 64'(err_cnt), 64'd1);
`endif

        // Backpressure: two packets queued, ready held low for 20 cycles.
        c2 = '0; c4 = '0; c6 = '0; c2[0] = 16'h0800;
        ea = pack(c2, c4, c6, 12'h00A, 1'b0, 128'hB1);
        c2 = '0; c4 = '0; c6 = '0; c4[3] = 32'h1E1F2021; c6[1] = 48'h000102030405;
        eb = pack(c2, c4, c6, 12'h01F, 1'b0, 128'hB2);
        vb = vlan_pops;
        sb = segs_pops;
        phv_ready = 1'b0;
        push_pkt(12'h00A, make_hdr(1'b1), 128'hB1, ea);
        push_pkt(12'h01F, make_hdr(1'b0), 128'hB2, eb);
        repeat (4) tick();
        check("bp_first_valid", 64'(phv_valid), 64'd1);
        held   = phv;
        stable = 1'b1;
        repeat (20) begin
            tick();
            stable = stable && phv_valid && (phv === held);
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_vlan_pops", 64'(vlan_pops - vb), 64'd1);
        check("bp_state_hold", 64'(dbg_state), 64'(ST_ASSEMBLE));
        phv_ready = 1'b1;
        tick();
        check("b2b_valid", 64'(phv_valid), 64'd1);
        check("b2b_new_data", 64'(phv[127:0]), 64'hB2);
        drain("bp");
        check("bp_vlan_pops_total", 64'(vlan_pops - vb), 64'd2);
        check("bp_segs_pops_total", 64'(segs_pops - sb), 64'd2);

        // Reset while waiting in EXTRACT: header not yet available.
        vb = vlan_pops;
        vq.push_back(12'h020);
        refresh();
        repeat (4) tick();
        check("abort_in_extract", 64'(dbg_state), 64'(ST_EXTRACT));
        areset = 1'b1;
        tick();
        check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        check("abort_valid", 64'(phv_valid), 64'd0);
        check("abort_rd", 64'({segs_fifo_rd, vlan_fifo_rd}), 64'd0);
        areset = 1'b0;
        tick();
        check("abort_no_pop", 64'(vlan_pops - vb), 64'd0);
        sq.push_back({128'hC3, make_hdr(1'b0)});
        c2 = '0; c4 = '0; c6 = '0; c2[2] = 16'h2829; c6[7] = 48'h646566676869;
        exp_q.push_back(pack(c2, c4, c6, 12'h020, 1'b0, 128'hC3));
        refresh();
        drain("abort");
        check("abort_pops", 64'(vlan_pops - vb), 64'd1);
`ifdef PARSER_ERR_CNT_EN
        check("err_cnt_after_rst", 64'(err_cnt), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
